// File: rtl/simmem_pkg.sv
// Shared widths and slot record for the simulated-memory delay releaser.
// The slot layout is fixed by the defaults below; top-level parameters must match them.
package simmem_pkg;

   localparam int DefIDWidth    = 8;
   localparam int DefNumSlots   = 16;
   localparam int DefDelayWidth = 6;

   // Rank counts older same-ID slots, so it must be able to hold 0..NumSlots.
   localparam int RankWidth     = $clog2(DefNumSlots + 1);
   localparam int SlotIdxWidth  = (DefNumSlots > 1) ? $clog2(DefNumSlots) : 1;

   typedef struct packed {
      logic                     valid;
      logic [DefIDWidth-1:0]    id;
      logic [DefDelayWidth-1:0] cnt;
      logic [RankWidth-1:0]     rank;
   } slot_t;

endpackage

// File: rtl/simmem_free_slot_finder.sv
// Priority encoder: lowest-index invalid slot plus an any-free flag.
// Purely combinational, no backpressure of its own.
module simmem_free_slot_finder
   import simmem_pkg::*;
#(
   parameter int NumSlots = DefNumSlots,
   parameter int IdxWidth = SlotIdxWidth
) (
   input  logic [NumSlots-1:0] slot_valid,
   output logic [IdxWidth-1:0] free_idx,
   output logic                any_free
);

   // Scan from the top so the lowest free index is the last one written.
   always_comb begin
      free_idx = '0;
      for (int s = NumSlots - 1; s >= 0; s--) begin
         if (!slot_valid[s]) begin
            free_idx = IdxWidth'(s);
         end
      end
   end

   assign any_free = ~&slot_valid;

endmodule

// File: rtl/simmem_delay_releaser.sv
// Holds each accepted transaction until its delay expires, then enables release per ID in order.
// Release appears delay+1 cycles after acceptance; in_ready_o drops only when every slot is busy.
module simmem_delay_releaser
   import simmem_pkg::*;
#(
   parameter int IDWidth    = DefIDWidth,
   parameter int NumSlots   = DefNumSlots,
   parameter int DelayWidth = DefDelayWidth
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [IDWidth-1:0]     in_id_i,
   input  logic [DelayWidth-1:0]  in_delay_i,
   output logic [2**IDWidth-1:0]  release_en_o,
   input  logic                   done_valid_i,
   input  logic [IDWidth-1:0]     done_id_i
);

   localparam int IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;

   slot_t                slots_q [NumSlots];
   slot_t                slots_d [NumSlots];
   logic [NumSlots-1:0]  slot_valid;
   logic [NumSlots-1:0]  slot_rel;
   logic [NumSlots-1:0]  slot_retire;
   logic [IdxWidth-1:0]  free_idx;
   logic                 any_free;
   logic                 accept;
   logic                 done_ok;
   logic [RankWidth-1:0] new_rank;

   simmem_free_slot_finder #(
      .NumSlots (NumSlots),
      .IdxWidth (IdxWidth)
   ) u_free_slot_finder (
      .slot_valid (slot_valid),
      .free_idx   (free_idx),
      .any_free   (any_free)
   );

   always_comb begin
      for (int s = 0; s < NumSlots; s++) begin
         slot_valid[s] = slots_q[s].valid;
         slot_rel[s]   = slots_q[s].valid && (slots_q[s].rank == '0) && (slots_q[s].cnt == '0);
      end
   end

   // Only the head of each ID's queue can drive its enable, which keeps per-ID order.
   always_comb begin
      release_en_o = '0;
      for (int s = 0; s < NumSlots; s++) begin
         if (slot_rel[s]) begin
            release_en_o[slots_q[s].id] = 1'b1;
         end
      end
   end

   assign in_ready_o = any_free;
   assign accept     = in_valid_i & any_free;
   assign done_ok    = done_valid_i & release_en_o[done_id_i];

   // The new slot's rank excludes a same-ID head retiring in the same cycle.
   always_comb begin
      new_rank = '0;
      for (int s = 0; s < NumSlots; s++) begin
         slot_retire[s] = done_ok && slots_q[s].valid && (slots_q[s].id == done_id_i) &&
                          (slots_q[s].rank == '0);
         if (slots_q[s].valid && (slots_q[s].id == in_id_i) && !slot_retire[s]) begin
            new_rank = new_rank + RankWidth'(1);
         end
      end
   end

   always_comb begin
      for (int s = 0; s < NumSlots; s++) begin
         slots_d[s] = slots_q[s];
         if (slots_q[s].valid) begin
            if (slot_retire[s]) begin
               slots_d[s].valid = 1'b0;
            end else begin
               if (slots_q[s].cnt != '0) begin
                  slots_d[s].cnt = slots_q[s].cnt - DelayWidth'(1);
               end
               if (done_ok && (slots_q[s].id == done_id_i) && (slots_q[s].rank != '0)) begin
                  slots_d[s].rank = slots_q[s].rank - RankWidth'(1);
               end
            end
         end
         if (accept && (free_idx == IdxWidth'(s))) begin
            slots_d[s].valid = 1'b1;
            slots_d[s].id    = in_id_i;
            slots_d[s].cnt   = in_delay_i;
            slots_d[s].rank  = new_rank;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < NumSlots; s++) begin
            slots_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NumSlots; s++) begin
            slots_q[s] <= slots_d[s];
         end
      end
   end

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Directed bench for simmem_delay_releaser: latency, per-ID ordering, full table, reset.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_simmem_delay_releaser;

   logic         clk_i;
   logic         rst_ni;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [7:0]   in_id_i;
   logic [5:0]   in_delay_i;
   logic [255:0] release_en_o;
   logic         done_valid_i;
   logic [7:0]   done_id_i;

   int n_checks    = 0;
   int n_err       = 0;
   int illegal_cnt = 0;

   simmem_delay_releaser dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_id_i      (in_id_i),
      .in_delay_i   (in_delay_i),
      .release_en_o (release_en_o),
      .done_valid_i (done_valid_i),
      .done_id_i    (done_id_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Protocol monitor: a done for an ID whose enable is low is illegal and must be ignored.
   always @(negedge clk_i) begin
      if (rst_ni && done_valid_i && !release_en_o[done_id_i]) begin
         illegal_cnt++;
         $display("monitor: done_valid_i for id %0d while its release enable is low", done_id_i);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic offer(input int id, input int dly);
      in_valid_i = 1'b1;
      in_id_i    = 8'(id);
      in_delay_i = 6'(dly);
   endtask

   task automatic done(input int id);
      done_valid_i = 1'b1;
      done_id_i    = 8'(id);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_ni       = 1'b0;
      in_valid_i   = 1'b0;
      in_id_i      = '0;
      in_delay_i   = '0;
      done_valid_i = 1'b0;
      done_id_i    = '0;
      #3;
      chk("rst_ready", in_ready_o, 1);
      chk("rst_rel", |release_en_o, 0);
      tick();
      tick();
      rst_ni = 1'b1;
      chk("post_rst_ready", in_ready_o, 1);
      chk("post_rst_rel", |release_en_o, 0);

      // ID 3, delay 5: enable at cycle 6, held until done, gone the cycle after.
      offer(3, 5);
      tick();
      in_valid_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk("a_rel3_early", release_en_o[3], 0);
         tick();
      end
      chk("a_rel3_c6", release_en_o[3], 1);
      tick();
      tick();
      chk("a_rel3_hold", release_en_o[3], 1);
      done(3);
      tick();
      done_valid_i = 1'b0;
      chk("a_rel3_retired", release_en_o[3], 0);

      // Same ID: the long first transaction blocks the short second one.
      offer(2, 10);
      tick();
      offer(2, 1);
      tick();
      in_valid_i = 1'b0;
      tick();
      chk("b_rel2_c3", release_en_o[2], 0);
      for (int k = 0; k < 7; k++) tick();
      chk("b_rel2_c10", release_en_o[2], 0);
      tick();
      chk("b_rel2_c11", release_en_o[2], 1);
      done(2);
      tick();
      chk("b_rel2_second", release_en_o[2], 1);
      tick();
      done_valid_i = 1'b0;
      chk("b_rel2_empty", release_en_o[2], 0);

      // Different IDs release independently.
      offer(1, 8);
      tick();
      offer(4, 2);
      tick();
      in_valid_i = 1'b0;
      tick();
      chk("c_rel4_c3", release_en_o[4], 0);
      tick();
      chk("c_rel4_c4", release_en_o[4], 1);
      chk("c_rel1_c4", release_en_o[1], 0);
      for (int k = 0; k < 4; k++) tick();
      chk("c_rel1_c8", release_en_o[1], 0);
      tick();
      chk("c_rel1_c9", release_en_o[1], 1);
      done(4);
      tick();
      done(1);
      tick();
      done_valid_i = 1'b0;
      chk("c_rel_both_gone", release_en_o[1] | release_en_o[4], 0);

      // Full table, then a retire and an offer in the same cycle.
      for (int s = 0; s < 16; s++) begin
         offer(16 + s, 0);
         tick();
      end
      in_valid_i = 1'b0;
      chk("d_full_ready", in_ready_o, 0);
      chk("d_rel21", release_en_o[21], 1);
      done(21);
      offer(50, 3);
      chk("d_ready_same_cycle", in_ready_o, 0);
      tick();
      done_valid_i = 1'b0;
      chk("d_ready_freed", in_ready_o, 1);
      tick();
      in_valid_i = 1'b0;
      chk("d_full_again", in_ready_o, 0);
      chk("d_slot5_id", dut.slots_q[5].id, 50);
      chk("d_rel21_gone", release_en_o[21], 0);
      chk("d_rel50_h1", release_en_o[50], 0);
      tick();
      chk("d_rel50_h2", release_en_o[50], 0);
      tick();
      chk("d_rel50_h3", release_en_o[50], 0);
      tick();
      chk("d_rel50_h4", release_en_o[50], 1);

      rst_ni = 1'b0;
      #1;
      chk("d_rst_ready", in_ready_o, 1);
      chk("d_rst_rel", |release_en_o, 0);
      tick();
      rst_ni = 1'b1;

      // Same-ID accept and retire in one cycle.
      offer(9, 0);
      tick();
      in_valid_i = 1'b0;
      chk("e_rel9_c1", release_en_o[9], 1);
      done(9);
      offer(9, 0);
      tick();
      in_valid_i = 1'b0;
      chk("e_rel9_c2", release_en_o[9], 1);
      chk("e_ready", in_ready_o, 1);
      done(9);
      tick();
      done_valid_i = 1'b0;
      chk("e_rel9_gone", release_en_o[9], 0);
      chk("e_no_illegal", illegal_cnt, 0);

      // Illegal done for ID 7 is flagged and must leave the pending ID 7 untouched.
      offer(7, 20);
      tick();
      in_valid_i = 1'b0;
      chk("f_rel7_c1", release_en_o[7], 0);
      done(7);
      tick();
      done_valid_i = 1'b0;
      chk("f_illegal_flagged", illegal_cnt, 1);
      for (int k = 0; k < 18; k++) tick();
      chk("f_rel7_c20", release_en_o[7], 0);
      tick();
      chk("f_rel7_c21", release_en_o[7], 1);
      done(7);
      tick();
      done_valid_i = 1'b0;
      chk("f_rel7_gone", release_en_o[7], 0);

      // Reset with five transactions in flight discards them all.
      for (int s = 0; s < 5; s++) begin
         offer(40 + s, 2 + s);
         tick();
      end
      in_valid_i = 1'b0;
      chk("g_rel40_before", release_en_o[40], 1);
      rst_ni = 1'b0;
      #1;
      chk("g_rst_rel", |release_en_o, 0);
      chk("g_rst_ready", in_ready_o, 1);
      tick();
      rst_ni = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("g_no_release", |release_en_o, 0);
         tick();
      end
      offer(40, 0);
      tick();
      in_valid_i = 1'b0;
      chk("g_new_rel40", release_en_o[40], 1);
      chk("g_illegal_total", illegal_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
